// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // Operation codes carried in funct3.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  // Control states of the unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Counter width able to hold the value DATA_WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator/remainder register and a single radix-2 multiply or divide step.
module muldiv_datapath #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic                      is_div,
  input  logic [DATA_WIDTH-1:0]     load_a,
  input  logic [DATA_WIDTH-1:0]     load_b,
  output logic [2*DATA_WIDTH-1:0]   acc_next
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic [W:0]     add_sum;
  logic [W:0]     trial;

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    trial    = acc[2*W-1:W-1] - {1'b0, opnd};
    acc_next = {add_sum, acc[W-1:1]};
    if (is_div) begin
      if (trial[W]) begin
        acc_next = {acc[2*W-2:0], 1'b0};
      end else begin
        acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
      end
    end
  end

  // Operand magnitudes are loaded on accept and the accumulator advances each busy cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{W{1'b0}}, load_a};
      opnd <= load_b;
    end else if (step) begin
      acc  <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e  state, state_next;
  muldiv_op_e     in_op, op_q;
  logic [CW-1:0]  counter;
  logic           sign_a, sign_b, special_q;
  logic [W-1:0]   special_val;
  logic           accept, last_step;
  logic           in_neg_a, in_neg_b, in_div_zero, in_overflow, in_special;
  logic [W-1:0]   mag_a, mag_b, in_special_val;
  logic [2*W-1:0] acc_next, product;
  logic [W-1:0]   quot, rem, final_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last_step = (state == BUSY) && (counter == CW'(1));

  // Decode the incoming operation: operand signs, magnitudes and short-cut cases.
  always_comb begin
    in_op          = muldiv_op_e'(op[2:0]);
    in_neg_a       = src_a[W-1] && (in_op == OP_MULH || in_op == OP_MULHSU ||
                                    in_op == OP_DIV  || in_op == OP_REM);
    in_neg_b       = src_b[W-1] && (in_op == OP_MULH || in_op == OP_DIV || in_op == OP_REM);
    mag_a          = in_neg_a ? -src_a : src_a;
    mag_b          = in_neg_b ? -src_b : src_b;
    in_div_zero    = in_op[2] && (src_b == '0);
    in_overflow    = (in_op == OP_DIV || in_op == OP_REM) && (src_a == MOST_NEG) && (src_b == '1);
    in_special     = in_div_zero || in_overflow;
    in_special_val = in_div_zero ? (in_op[1] ? src_a : '1) : (in_op[1] ? '0 : src_a);
  end

  // Sign fix-up of the final iteration and selection of the architectural result.
  always_comb begin
    product   = (sign_a ^ sign_b) ? -acc_next : acc_next;
    quot      = (sign_a ^ sign_b) ? -acc_next[W-1:0] : acc_next[W-1:0];
    rem       = sign_a ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
    final_val = (op_q == OP_MUL) ? product[W-1:0] : product[2*W-1:W];
    if (special_q) begin
      final_val = special_val;
    end else if (op_q[2]) begin
      final_val = op_q[1] ? rem : quot;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (counter == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Operation context, iteration counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter     <= '0;
      op_q        <= OP_MUL;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      special_q   <= 1'b0;
      special_val <= '0;
      result      <= '0;
    end else if (flush) begin
      counter     <= '0;
      result      <= '0;
    end else if (accept) begin
      counter     <= in_special ? CW'(1) : CW'(DATA_WIDTH);
      op_q        <= in_op;
      sign_a      <= in_neg_a;
      sign_b      <= in_neg_b;
      special_q   <= in_special;
      special_val <= in_special_val;
    end else if (state == BUSY) begin
      counter     <= counter - CW'(1);
      if (last_step) begin
        result    <= final_val;
      end
    end
  end

  muldiv_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == BUSY),
    .is_div   (op_q[2]),
    .load_a   (mag_a),
    .load_b   (mag_b),
    .acc_next (acc_next)
  );

endmodule
